mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port of the multicycle core between two requesters: m0 (CPU fetch/load/store) and m1 (program loader/DMA).
- Latches the granted request, drives the memory port until mem_rdy, then returns a one-cycle response pulse.
- Selects fixed or round-robin priority and enforces a response timeout.
- Sits between mc_cpu's memory interface and the memory unit.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RR_MODE, 1, 1 = round-robin between m0/m1; 0 = fixed priority, m0 always wins.
- TIMEOUT, 256, maximum BUSY cycles waiting for mem_rdy; 0 disables the timeout.
- CW, 9, timeout counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  single clock; all state on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  m0 transaction request; level, held with payload until m0_rdy.
- m0_addr  in  AW  m0 byte address.
- m0_wdata  in  DW  m0 write data.
- m0_we  in  1  m0 write enable (1 = write, 0 = read).
- m0_rdy  out  1  one-cycle completion pulse to m0.
- m0_rdata  out  DW  m0 read data; valid while m0_rdy = 1.
- m0_err  out  1  timeout error; qualified by m0_rdy.
- m1_req, m1_addr, m1_wdata, m1_we, m1_rdy, m1_rdata, m1_err  same as m0, for m1.
- mem_req  out  1  memory transaction valid.
- mem_addr  out  AW  latched address.
- mem_wdata  out  DW  latched write data.
- mem_we  out  1  latched write enable, gated by mem_req.
- mem_rdy  in  1  memory completion; sampled only while mem_req = 1.
- mem_rdata  in  DW  memory read data; valid with mem_rdy.
- busy  out  1  high in BUSY or RESP.
- grant_id  out  1  requester owning the current or last transaction.

Behaviour:
- Reset values:
  - State IDLE.
  - mem_req, mem_we, mN_rdy, mN_err, busy: 0.
  - mem_addr, mem_wdata, mN_rdata: 0.
  - grant_id: 0.
  - last_grant: 1, so m0 wins the first tie.
  - Timeout counter: 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting, RR_MODE = 1: grant the requester that is not last_grant.
  - Both requesting, RR_MODE = 0: grant m0.
  - On grant: latch addr/wdata/we of the winner into the mem_* registers, set grant_id and last_grant, clear the counter, go to BUSY.
- BUSY:
  - mem_req = 1; mem_we = latched we.
  - If mem_rdy = 1: capture mem_rdata into the winner's rdata register (writes return mem_rdata unchanged), err = 0, go to RESP.
  - Else, if TIMEOUT != 0 and counter = TIMEOUT-1: rdata = 0, err = 1, go to RESP.
  - Else: increment the counter.
- RESP:
  - mem_req = 0.
  - Winner's mN_rdy = 1 for exactly one cycle; the other requester's rdy stays 0.
  - Next state: IDLE, unconditionally.
- Outputs are fully registered; no combinational path from any input to any output.
- Latency: req sampled in IDLE at edge 0 → mem_req high at cycle 1 → mem_rdy at cycle k (k ≥ 1) → mN_rdy at cycle k+1. Minimum is 3 cycles from request to rdy; single-requester throughput is one transaction per 3 cycles.
- Requester rule: keep req and payload stable until rdy. In the rdy cycle, either drop req or present the next transaction; the following IDLE cycle samples the updated req, so there is no double issue.
- A requester that drops req before its grant is simply not served. A requester that drops req after its grant is still completed and still receives rdy.
- mN_rdata and mN_err hold their values after the rdy pulse until that requester's next completion.
- mem_rdy while not in BUSY is ignored.
- mem_rdy arriving in the same cycle the counter hits TIMEOUT-1: the response wins, err = 0.
- Asserting sys_rst_n low mid-transaction aborts it: no rdy is issued, and mem_req drops immediately (asynchronously).

Test Plan:
- Single m0 read, addr 0x0040_0000, mem_rdy one cycle after mem_req with rdata 0x0000_0293 → mem_addr = 0x0040_0000, mem_we = 0; m0_rdy pulses exactly once with m0_rdata = 0x0000_0293, m0_err = 0; m1_rdy stays 0.
- RR_MODE = 1, m0 and m1 both hold req continuously, memory always ready next cycle → grants alternate m0, m1, m0, m1; each rdy spaced by 3 cycles; grant_id toggles.
- RR_MODE = 0, same stimulus → m0 served every transaction; m1 starved; m1_rdy never pulses while m0_req stays high.
- m1 write, addr 0x1000_0000, wdata 0xDEAD_BEEF, mem_rdy held low, TIMEOUT = 8 → mem_req high for exactly 8 cycles with mem_we = 1 and mem_wdata = 0xDEAD_BEEF; then m1_rdy = 1 with m1_err = 1 and m1_rdata = 0; back to IDLE.
- sys_rst_n pulsed low in the middle of BUSY → mem_req = 0 immediately; no rdy pulse; after release, the next request with both masters requesting goes to m0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the shared instruction/data memory port of the multicycle core.
// m0 is the CPU and m1 is the loader/DMA. Every output comes straight from a register.
//
// state | meaning
// IDLE  | no transaction in flight; samples m0_req/m1_req and picks a winner
// BUSY  | mem_req is driven to memory; waits for mem_rdy or a timeout
// RESP  | the winner's one-cycle rdy pulse is out; returns to IDLE
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 256,
  parameter int CW      = 9
) (
  input  logic          clk,
  input  logic          sys_rst_n,

  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_we,
  output logic          m0_rdy,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,

  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_we,
  output logic          m1_rdy,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,

  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic          mem_rdy,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy,
  output logic          grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam bit            TO_EN    = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;

  state_t        state;
  logic          last_grant;
  logic [CW-1:0] cnt;
  logic          pick;
  logic          any_req;
  logic          done;
  logic [DW-1:0] rsp_data;

  assign any_req = m0_req | m1_req;

  // A lone request always wins; a tie goes to m0 unless round-robin hands it to the other side.
  always_comb begin
    pick = m1_req;
    if (m0_req && m1_req) begin
      pick = (RR_MODE != 0) ? ~last_grant : 1'b0;
    end
  end

  // A memory response in the last allowed cycle beats the timeout.
  assign done     = mem_rdy || (TO_EN && (cnt == CNT_LAST));
  assign rsp_data = mem_rdy ? mem_rdata : '0;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      grant_id   <= 1'b0;
      m0_rdy     <= 1'b0;
      m0_rdata   <= '0;
      m0_err     <= 1'b0;
      m1_rdy     <= 1'b0;
      m1_rdata   <= '0;
      m1_err     <= 1'b0;
    end else begin
      m0_rdy <= 1'b0;
      m1_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= BUSY;
            mem_req    <= 1'b1;
            busy       <= 1'b1;
            grant_id   <= pick;
            last_grant <= pick;
            cnt        <= '0;
            mem_addr   <= pick ? m1_addr  : m0_addr;
            mem_wdata  <= pick ? m1_wdata : m0_wdata;
            mem_we     <= pick ? m1_we    : m0_we;
          end
        end
        BUSY: begin
          if (done) begin
            state   <= RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (grant_id) begin
              m1_rdy   <= 1'b1;
              m1_rdata <= rsp_data;
              m1_err   <= ~mem_rdy;
            end else begin
              m0_rdy   <= 1'b1;
              m0_rdata <= rsp_data;
              m0_err   <= ~mem_rdy;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin instance and a fixed-priority instance,
// each checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TO0 = 8;
  localparam int TO1 = 5;

  localparam int M_QUIET = 0;
  localparam int M_ECHO  = 1;
  localparam int M_HOLD  = 2;
  localparam int M_STALL = 3;
  localparam int M_LATE  = 4;
  localparam int M_RAND  = 5;

  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req       [2][2];
  logic [AW-1:0] addr      [2][2];
  logic [DW-1:0] wdata     [2][2];
  logic          we        [2][2];
  logic          rdy       [2][2];
  logic [DW-1:0] rdata     [2][2];
  logic          err       [2][2];
  logic          mem_req   [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic          mem_we    [2];
  logic          mem_rdy   [2];
  logic [DW-1:0] mem_rdata [2];
  logic          busy      [2];
  logic          grant_id  [2];

  mem_port_arbiter #(.AW(AW), .DW(DW), .RR_MODE(1), .TIMEOUT(TO0), .CW(4)) dut_rr (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .m0_req(req[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]), .m0_we(we[0][0]),
    .m0_rdy(rdy[0][0]), .m0_rdata(rdata[0][0]), .m0_err(err[0][0]),
    .m1_req(req[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]), .m1_we(we[0][1]),
    .m1_rdy(rdy[0][1]), .m1_rdata(rdata[0][1]), .m1_err(err[0][1]),
    .mem_req(mem_req[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]),
    .mem_rdy(mem_rdy[0]), .mem_rdata(mem_rdata[0]),
    .busy(busy[0]), .grant_id(grant_id[0])
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .RR_MODE(0), .TIMEOUT(TO1), .CW(3)) dut_fp (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .m0_req(req[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]), .m0_we(we[1][0]),
    .m0_rdy(rdy[1][0]), .m0_rdata(rdata[1][0]), .m0_err(err[1][0]),
    .m1_req(req[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]), .m1_we(we[1][1]),
    .m1_rdy(rdy[1][1]), .m1_rdata(rdata[1][1]), .m1_err(err[1][1]),
    .mem_req(mem_req[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]),
    .mem_rdy(mem_rdy[1]), .mem_rdata(mem_rdata[1]),
    .busy(busy[1]), .grant_id(grant_id[1])
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int i, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst%0d got=%0h exp=%0h t=%0t", tag, i, got, exp, $time);
    end
  endtask

  // Reference model: tracks the open transaction (owner, cycles spent waiting) and the
  // values each output should show after every clock edge.
  int            phase [2];   // 0 free, 1 waiting on memory, 2 answering
  int            owner [2];
  int            last  [2];
  int            age   [2];
  int            tov   [2];
  bit            rr    [2];
  logic          e_mreq [2], e_mwe [2], e_busy [2], e_gid [2];
  logic [AW-1:0] e_maddr [2];
  logic [DW-1:0] e_mwdata [2];
  logic          e_rdy [2][2], e_err [2][2];
  logic [DW-1:0] e_rdata [2][2];

  function automatic int winner(input int i);
    if (req[i][0] && req[i][1]) return rr[i] ? 1 - last[i] : 0;
    return req[i][1] ? 1 : 0;
  endfunction

  task automatic model_reset(input int i);
    phase[i] = 0; last[i] = 1; age[i] = 0; owner[i] = 0;
    e_mreq[i] = 0; e_mwe[i] = 0; e_busy[i] = 0; e_gid[i] = 0;
    e_maddr[i] = '0; e_mwdata[i] = '0;
    for (int m = 0; m < 2; m++) begin
      e_rdy[i][m] = 0; e_err[i][m] = 0; e_rdata[i][m] = '0;
    end
  endtask

  task automatic model_step(input int i);
    int w;
    e_rdy[i][0] = 0;
    e_rdy[i][1] = 0;
    if (phase[i] == 0) begin
      if (req[i][0] || req[i][1]) begin
        w = winner(i);
        owner[i] = w; last[i] = w; age[i] = 0; phase[i] = 1;
        e_mreq[i] = 1; e_busy[i] = 1; e_gid[i] = (w == 1);
        e_mwe[i] = we[i][w]; e_maddr[i] = addr[i][w]; e_mwdata[i] = wdata[i][w];
      end
    end else if (phase[i] == 1) begin
      if (mem_rdy[i] || (age[i] + 1 == tov[i])) begin
        phase[i] = 2; e_mreq[i] = 0; e_mwe[i] = 0;
        e_rdy[i][owner[i]]   = 1;
        e_rdata[i][owner[i]] = mem_rdy[i] ? mem_rdata[i] : '0;
        e_err[i][owner[i]]   = !mem_rdy[i];
      end else begin
        age[i]++;
      end
    end else begin
      phase[i] = 0;
      e_busy[i] = 0;
    end
  endtask

  task automatic compare(input int i);
    check("mem_req", i, mem_req[i], e_mreq[i]);
    check("mem_we", i, mem_we[i], e_mwe[i]);
    check("mem_addr", i, mem_addr[i], e_maddr[i]);
    check("mem_wdata", i, mem_wdata[i], e_mwdata[i]);
    check("busy", i, busy[i], e_busy[i]);
    check("grant_id", i, grant_id[i], e_gid[i]);
    for (int m = 0; m < 2; m++) begin
      check(m ? "m1_rdy" : "m0_rdy", i, rdy[i][m], e_rdy[i][m]);
      check(m ? "m1_rdata" : "m0_rdata", i, rdata[i][m], e_rdata[i][m]);
      check(m ? "m1_err" : "m0_err", i, err[i][m], e_err[i][m]);
    end
  endtask

  int            mode;
  int            p_rdy;
  int            cyc;
  logic [DW-1:0] echo_data;
  int            rdy_cnt [2][2];
  int            mreq_cyc [2];
  int            run [2];
  int            last_rdy_t [2];
  int            prev_own [2];

  task automatic bookkeep(input int i);
    run[i] = mem_req[i] ? run[i] + 1 : 0;
    if (mem_req[i]) mreq_cyc[i]++;
    for (int m = 0; m < 2; m++) begin
      if (rdy[i][m]) begin
        rdy_cnt[i][m]++;
        if (mode == M_HOLD) begin
          if (last_rdy_t[i] >= 0) check("rdy_gap", i, cyc - last_rdy_t[i], 3);
          if (i == 0 && prev_own[0] >= 0) check("rr_alternate", i, m, 1 - prev_own[0]);
          if (i == 1) check("fixed_m0_wins", i, m, 0);
          check("grant_matches_rdy", i, grant_id[i], m);
        end
        last_rdy_t[i] = cyc;
        prev_own[i]   = m;
      end
    end
  endtask

  task automatic new_txn(input int i, input int m);
    req[i][m]   = 1'b1;
    addr[i][m]  = $urandom;
    wdata[i][m] = $urandom;
    we[i][m]    = 1'($urandom_range(0, 1));
  endtask

  task automatic drive(input int i);
    case (mode)
      M_QUIET: begin
        req[i][0] = 0; req[i][1] = 0;
        mem_rdy[i] = 1'($urandom_range(0, 1));
        mem_rdata[i] = $urandom;
      end
      M_ECHO, M_STALL, M_LATE: begin
        if (mode == M_ECHO) mem_rdy[i] = mem_req[i];
        else if (mode == M_LATE) mem_rdy[i] = mem_req[i] && (run[i] == tov[i]);
        else mem_rdy[i] = 1'b0;
        mem_rdata[i] = (mode == M_STALL) ? DW'($urandom) : echo_data;
        for (int m = 0; m < 2; m++) if (rdy[i][m]) req[i][m] = 0;
      end
      M_HOLD: begin
        mem_rdy[i] = 1'b1;
        mem_rdata[i] = $urandom;
        for (int m = 0; m < 2; m++) if (rdy[i][m] || !req[i][m]) new_txn(i, m);
      end
      default: begin
        mem_rdy[i] = ($urandom_range(0, 99) < p_rdy);
        mem_rdata[i] = $urandom;
        for (int m = 0; m < 2; m++) begin
          if (rdy[i][m]) begin
            if ($urandom_range(0, 1) == 1) new_txn(i, m);
            else req[i][m] = 0;
          end else if (!req[i][m]) begin
            if ($urandom_range(0, 3) == 0) new_txn(i, m);
          end else if ($urandom_range(0, 31) == 0) begin
            req[i][m] = 0;
          end
        end
      end
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!sys_rst_n) model_reset(i);
      else model_step(i);
      compare(i);
      bookkeep(i);
      drive(i);
    end
  endtask

  int base0 [2], base1 [2], base_mq [2];
  int diff;

  initial begin
    tov[0] = TO0; tov[1] = TO1;
    rr[0] = 1'b1; rr[1] = 1'b0;
    cyc = 0; p_rdy = 50; echo_data = '0;
    for (int i = 0; i < 2; i++) begin
      for (int m = 0; m < 2; m++) begin
        req[i][m] = 0; addr[i][m] = '0; wdata[i][m] = '0; we[i][m] = 0;
        rdy_cnt[i][m] = 0;
      end
      mem_rdy[i] = 0; mem_rdata[i] = '0;
      mreq_cyc[i] = 0; run[i] = 0; last_rdy_t[i] = -1; prev_own[i] = -1;
      model_reset(i);
    end
    mode = M_QUIET;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    repeat (2) tick();

    // single m0 read answered immediately
    echo_data = 32'h0000_0293;
    mode = M_ECHO;
    for (int i = 0; i < 2; i++) begin
      req[i][0] = 1; addr[i][0] = 32'h0040_0000; wdata[i][0] = $urandom; we[i][0] = 0;
      base0[i] = rdy_cnt[i][0]; base1[i] = rdy_cnt[i][1];
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      check("read_mem_req", i, mem_req[i], 1);
      check("read_mem_addr", i, mem_addr[i], 32'h0040_0000);
      check("read_mem_we", i, mem_we[i], 0);
    end
    repeat (4) tick();
    for (int i = 0; i < 2; i++) begin
      check("read_m0_pulses", i, rdy_cnt[i][0] - base0[i], 1);
      check("read_m1_pulses", i, rdy_cnt[i][1] - base1[i], 0);
      check("read_m0_rdata", i, rdata[i][0], 32'h0000_0293);
      check("read_m0_err", i, err[i][0], 0);
    end

    // both masters hold their requests, memory always ready
    mode = M_QUIET;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      last_rdy_t[i] = -1; prev_own[i] = -1;
      base0[i] = rdy_cnt[i][0]; base1[i] = rdy_cnt[i][1];
    end
    mode = M_HOLD;
    repeat (24) tick();
    diff = (rdy_cnt[0][0] - base0[0]) - (rdy_cnt[0][1] - base1[0]);
    check("rr_balance", 0, (diff >= -1 && diff <= 1), 1);
    check("rr_m1_served", 0, (rdy_cnt[0][1] - base1[0]) >= 3, 1);
    check("fp_m1_starved", 1, rdy_cnt[1][1] - base1[1], 0);
    check("fp_m0_served", 1, (rdy_cnt[1][0] - base0[1]) >= 6, 1);

    // m1 write with memory never answering: timeout
    mode = M_QUIET;
    repeat (4) tick();
    mode = M_STALL;
    for (int i = 0; i < 2; i++) begin
      req[i][1] = 1; addr[i][1] = 32'h1000_0000; wdata[i][1] = 32'hDEAD_BEEF; we[i][1] = 1;
      base_mq[i] = mreq_cyc[i]; base1[i] = rdy_cnt[i][1];
    end
    tick();
    for (int i = 0; i < 2; i++) check("to_mem_we", i, mem_we[i], 1);
    repeat (13) tick();
    for (int i = 0; i < 2; i++) begin
      check("to_mem_req_cycles", i, mreq_cyc[i] - base_mq[i], tov[i]);
      check("to_m1_pulses", i, rdy_cnt[i][1] - base1[i], 1);
      check("to_m1_err", i, err[i][1], 1);
      check("to_m1_rdata", i, rdata[i][1], 0);
      check("to_wdata_held", i, mem_wdata[i], 32'hDEAD_BEEF);
      check("to_back_idle", i, busy[i], 0);
    end

    // response arrives in the last cycle before the timeout would fire
    mode = M_QUIET;
    repeat (4) tick();
    echo_data = 32'h1234_5678;
    mode = M_LATE;
    for (int i = 0; i < 2; i++) begin
      req[i][0] = 1; addr[i][0] = $urandom; wdata[i][0] = $urandom; we[i][0] = 0;
      base_mq[i] = mreq_cyc[i]; base0[i] = rdy_cnt[i][0];
    end
    repeat (14) tick();
    for (int i = 0; i < 2; i++) begin
      check("late_mem_req_cycles", i, mreq_cyc[i] - base_mq[i], tov[i]);
      check("late_m0_pulses", i, rdy_cnt[i][0] - base0[i], 1);
      check("late_m0_err", i, err[i][0], 0);
      check("late_m0_rdata", i, rdata[i][0], 32'h1234_5678);
    end

    // reset in the middle of a transaction
    mode = M_QUIET;
    repeat (4) tick();
    mode = M_STALL;
    for (int i = 0; i < 2; i++) begin
      req[i][0] = 1; addr[i][0] = $urandom; wdata[i][0] = $urandom; we[i][0] = 1;
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      check("pre_rst_mem_req", i, mem_req[i], 1);
      base0[i] = rdy_cnt[i][0]; base1[i] = rdy_cnt[i][1];
    end
    #2 sys_rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_mem_req_async", i, mem_req[i], 0);
      check("rst_mem_we_async", i, mem_we[i], 0);
      check("rst_busy_async", i, busy[i], 0);
    end
    repeat (2) tick();
    for (int i = 0; i < 2; i++) check("rst_no_rdy", i, rdy_cnt[i][0] + rdy_cnt[i][1] - base0[i] - base1[i], 0);
    sys_rst_n = 1'b1;
    mode = M_ECHO;
    for (int i = 0; i < 2; i++) begin
      new_txn(i, 0);
      new_txn(i, 1);
    end
    tick();
    for (int i = 0; i < 2; i++) check("rst_first_grant_m0", i, grant_id[i], 0);
    repeat (8) tick();

    // random traffic, alternating responsive and sluggish memory
    mode = M_RAND;
    for (int k = 0; k < 6; k++) begin
      p_rdy = (k % 2 == 1) ? 4 : 45;
      repeat (400) tick();
    end
    mode = M_QUIET;
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
